de_frame_responder: RTL and testbench
=====================================

Name: de_frame_responder

Overview:
- Responder end of the drawing-engine memory port (de_*). Accepts one word-wide frame-store request at a time from a drawing initiator and executes it on a synchronous SRAM-style frame store, honouring active-low byte lanes.
- Returns a one-cycle de_ack per transfer and, for reads, de_r_data.
- Sits between drawing cells (e.g. the dithering cell) and the frame-store memory.

Parameters:
- WAIT_CYCLES, 2: cycles mem_cs is held per memory access; legal range 1..15.
- ADDR_W, 18: word address width of de_addr and mem_addr.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- de_req  in  1  request; level, held by initiator until de_ack.
- de_ack  out  1  transfer complete; registered, high exactly one cycle.
- de_addr  in  ADDR_W  word address.
- de_nbyte  in  4  active-low byte enables; bit i = 0 enables byte lane i (bits 8i+7:8i).
- de_rnw  in  1  1 = read, 0 = write.
- de_w_data  in  32  write data.
- de_r_data  out  32  read data; registered.
- mem_cs  out  1  memory select.
- mem_we  out  1  memory write strobe (valid with mem_cs).
- mem_be  out  4  active-high byte enables to memory.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid in last cycle of a read access.

Behaviour:
- Reset values: de_ack=0, de_r_data=0, mem_cs=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, FSM=IDLE, wait counter=0.
- Reset asserted mid-operation: all outputs drop to reset values immediately (asynchronously), no de_ack issued, and the in-flight transfer is abandoned. A partial write is acceptable.
- States:
  - IDLE: on an edge with de_req=1, latch de_addr, de_nbyte, de_rnw, de_w_data into holding registers and go to ACCESS. The initiator may change its inputs after acceptance; the responder uses only the latched values.
  - ACCESS: mem_cs=1 for exactly WAIT_CYCLES cycles.
    - Write: mem_we=1, mem_be=~nbyte_q, mem_wdata=w_data_q.
    - Read: mem_we=0, mem_be=4'b1111.
    - On the last cycle, capture mem_rdata into de_r_data (reads only), then go to ACK.
  - ACK: de_ack=1 and mem_cs=0 for one cycle; next state is always IDLE.
- Latency: de_ack is high in the (WAIT_CYCLES+1)th cycle after the accepting edge. The initiator updates address and data on the edge that samples de_ack, so the mandatory IDLE cycle after ACK prevents re-sampling stale inputs. Throughput is one transfer per WAIT_CYCLES+2 cycles while de_req is held high.
- Null write (de_rnw=0, de_nbyte=4'b1111): full handshake and ACCESS timing with mem_cs=1, mem_we=0; memory contents unchanged.
- de_r_data changes only on read completion; it holds its value across writes and idle cycles.
- de_req dropping while in ACCESS/ACK is ignored; the transfer completes and is acked.
- Address is used as given; there is no wrap-around or range check.

Optional Feature:
- Macro DE_RMW_EN: support for memories without byte enables.
  - Defined: mem_be is always 4'b1111. A partial write (nbyte neither 0000 nor 1111) runs state RMW_RD (WAIT_CYCLES cycles, read) and then RMW_WR (WAIT_CYCLES cycles, write of the merged word: enabled lanes from w_data_q, others from the read word). After RMW_WR the FSM goes to ACK. Total latency for a partial write is 2*WAIT_CYCLES+1 cycles; full writes, null writes and reads are unchanged. de_r_data is NOT updated by the RMW read.
  - Not defined: direct byte-enabled write as above; states RMW_RD/RMW_WR are absent.

Decomposition:
- Package de_pkg holds:
  - the FSM state enum (IDLE, ACCESS, ACK, RMW_RD, RMW_WR);
  - NBYTE_ALL=4'b0000 and NBYTE_NONE=4'b1111;
  - DE_ADDR_W=18 and DE_DATA_W=32.
- Sub-module de_byte_merge (combinational): inputs old word, new word and active-low nbyte; output the merged word. Used only under DE_RMW_EN.

Test Plan:
- Full write, WAIT_CYCLES=2: addr=18'h00010, nbyte=0000, data=32'hDEADBEEF, rnw=0 -> mem_cs/mem_we high 2 cycles, mem_be=1111, de_ack on the 3rd cycle after acceptance, memory word = DEADBEEF.
- Byte write: nbyte=1101 into word 32'h11223344 with data 32'hAABBCCDD -> mem_be=0010; word becomes 11 22 CC 44 (32'h1122CC44). With DE_RMW_EN: same final word, mem_be=1111, de_ack 5 cycles after acceptance.
- Read-back: read addr 18'h00010 -> de_r_data=DEADBEEF on the de_ack cycle; it still holds DEADBEEF after a subsequent write.
- Back-to-back: de_req held high for 4 writes with addresses advanced on each de_ack -> 4 acks spaced exactly WAIT_CYCLES+2=4 cycles apart; each write lands at its own address with no stale re-sample.
- Null write: nbyte=1111 -> de_ack delivered, mem_we never high, memory unchanged.
- Reset mid-ACCESS: assert rst in cycle 1 of ACCESS -> mem_cs/de_ack are 0 immediately with no ack; after release, a new request completes normally.

Source files
------------

// File: rtl/de_pkg.sv
// Shared types and constants for the drawing-engine frame-store responder.
// State enum, byte-enable constants and bus widths.
package de_pkg;

  localparam int DE_ADDR_W = 18;
  localparam int DE_DATA_W = 32;

  localparam logic [3:0] NBYTE_ALL  = 4'b0000;
  localparam logic [3:0] NBYTE_NONE = 4'b1111;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    ACK,
    RMW_RD,
    RMW_WR
  } de_state_e;

endpackage

// File: rtl/de_byte_merge.sv
// Combinational byte-lane merge: enabled lanes (nbyte bit low) take the new
// word, disabled lanes keep the old word.
module de_byte_merge
  import de_pkg::*;
(
  input  logic [DE_DATA_W-1:0] i_old,
  input  logic [DE_DATA_W-1:0] i_new,
  input  logic [3:0]           i_nbyte,
  output logic [DE_DATA_W-1:0] o_word
);

  always_comb begin
    o_word = i_old;
    for (int i = 0; i < 4; i++) begin
      if (!i_nbyte[i]) o_word[8*i +: 8] = i_new[8*i +: 8];
    end
  end

endmodule

// File: rtl/de_frame_responder.sv
// Drawing-engine memory port responder driving a synchronous frame store.
// Define DE_RMW_EN for memories without byte enables (read-modify-write).
module de_frame_responder
  import de_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = DE_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              de_req,
  output logic              de_ack,
  input  logic [ADDR_W-1:0] de_addr,
  input  logic [3:0]        de_nbyte,
  input  logic              de_rnw,
  input  logic [31:0]       de_w_data,
  output logic [31:0]       de_r_data,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  de_state_e  r_state;
  logic [3:0] r_cnt;
  logic       r_rnw;

  // mem_addr and mem_wdata double as the request holding registers
`ifdef DE_RMW_EN
  logic [3:0]  r_nbyte;
  logic [31:0] w_merged;
  logic        w_partial;

  assign w_partial = (de_nbyte != NBYTE_ALL) && (de_nbyte != NBYTE_NONE);

  de_byte_merge u_merge (
    .i_old   (mem_rdata),
    .i_new   (mem_wdata),
    .i_nbyte (r_nbyte),
    .o_word  (w_merged)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rnw     <= 1'b0;
      de_ack    <= 1'b0;
      de_r_data <= '0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef DE_RMW_EN
      r_nbyte   <= NBYTE_NONE;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (de_req) begin
            r_rnw     <= de_rnw;
            mem_addr  <= de_addr;
            mem_wdata <= de_w_data;
            mem_cs    <= 1'b1;
            r_cnt     <= '0;
`ifdef DE_RMW_EN
            r_nbyte <= de_nbyte;
            mem_be  <= 4'b1111;
            if (!de_rnw && w_partial) begin
              mem_we  <= 1'b0;
              r_state <= RMW_RD;
            end else begin
              mem_we  <= !de_rnw && (de_nbyte != NBYTE_NONE);
              r_state <= ACCESS;
            end
`else
            mem_be  <= de_rnw ? 4'b1111 : ~de_nbyte;
            mem_we  <= !de_rnw && (de_nbyte != NBYTE_NONE);
            r_state <= ACCESS;
`endif
          end
        end
        ACCESS: begin
          if (r_cnt == LAST) begin
            if (r_rnw) de_r_data <= mem_rdata;
            mem_cs  <= 1'b0;
            mem_we  <= 1'b0;
            de_ack  <= 1'b1;
            r_cnt   <= '0;
            r_state <= ACK;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ACK: begin
          de_ack  <= 1'b0;
          r_state <= IDLE;
        end
`ifdef DE_RMW_EN
        RMW_RD: begin
          if (r_cnt == LAST) begin
            mem_wdata <= w_merged;
            mem_we    <= 1'b1;
            r_cnt     <= '0;
            r_state   <= RMW_WR;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        RMW_WR: begin
          if (r_cnt == LAST) begin
            mem_cs  <= 1'b0;
            mem_we  <= 1'b0;
            de_ack  <= 1'b1;
            r_cnt   <= '0;
            r_state <= ACK;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_de_frame_responder.sv
// Self-checking bench for de_frame_responder: directed steps plus random
// transfers checked against a byte-level reference memory.
module tb_de_frame_responder;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        de_req;
  logic        de_ack;
  logic [17:0] de_addr;
  logic [3:0]  de_nbyte;
  logic        de_rnw;
  logic [31:0] de_w_data;
  logic [31:0] de_r_data;
  logic        mem_cs;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [17:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  de_frame_responder #(.WAIT_CYCLES(W), .ADDR_W(18)) dut (
    .clk       (clk),
    .rst       (rst),
    .de_req    (de_req),
    .de_ack    (de_ack),
    .de_addr   (de_addr),
    .de_nbyte  (de_nbyte),
    .de_rnw    (de_rnw),
    .de_w_data (de_w_data),
    .de_r_data (de_r_data),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // frame-store SRAM the DUT drives
  bit [31:0] sram [0:262143];
  assign mem_rdata = sram[mem_addr];
  always @(posedge clk) begin
    if (mem_cs && mem_we) begin
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) sram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // reference model
  bit [31:0] ref_mem [bit [17:0]];
  logic [31:0] exp_rd = 32'h0;

  int          cs_n, we_n;
  logic [3:0]  be_or, be_and;
  logic [31:0] rd_at_ack;
  int          last_ack;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] ref_get(input logic [17:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic void ref_write(input logic [17:0] a, input logic [3:0] nb,
                                    input logic [31:0] wd);
    bit [31:0] w;
    bit [31:0] m;
    w = ref_get(a);
    for (int i = 0; i < 4; i++) begin
      m = 32'hFF << (8 * i);
      if (nb[i] == 1'b0) w = (w & ~m) | (wd & m);
    end
    ref_mem[a] = w;
  endfunction

  function automatic bit is_partial(input logic [3:0] nb);
    return nb != 4'b0000 && nb != 4'b1111;
  endfunction

  function automatic int exp_lat(input logic rnw, input logic [3:0] nb);
`ifdef DE_RMW_EN
    if (!rnw && is_partial(nb)) return 2 * W + 1;
`endif
    return W + 1;
  endfunction

  function automatic logic [3:0] exp_be(input logic rnw, input logic [3:0] nb);
`ifdef DE_RMW_EN
    return 4'b1111;
`else
    return rnw ? 4'b1111 : ~nb;
`endif
  endfunction

  task automatic xfer(input logic [17:0] a, input logic [3:0] nb,
                      input logic rnw, input logic [31:0] wd,
                      input bit hold, input bit drop, output int lat);
    bit got;
    de_req = 1'b1; de_addr = a; de_nbyte = nb; de_rnw = rnw; de_w_data = wd;
    cs_n = 0; we_n = 0; be_or = 4'h0; be_and = 4'hF;
    lat = -1; got = 1'b0; rd_at_ack = 'x;
    @(posedge clk); #1;
    de_addr = 18'($urandom); de_nbyte = 4'($urandom);
    de_rnw = 1'($urandom); de_w_data = $urandom;
    if (drop) de_req = 1'b0;
    for (int k = 1; k <= 64 && !got; k++) begin
      if (mem_cs) begin
        cs_n++;
        be_or  = be_or | mem_be;
        be_and = be_and & mem_be;
        if (mem_we) we_n++;
      end
      @(posedge clk); #1;
      if (de_ack) begin
        got = 1'b1; lat = k + 1; last_ack = cyc; rd_at_ack = de_r_data;
      end
    end
    chk("ack_seen", 32'(got), 32'h1);
    if (got) begin
      chk("cs_in_ack", 32'(mem_cs), 32'h0);
      @(posedge clk); #1;
      chk("ack_one_cycle", 32'(de_ack), 32'h0);
    end
    if (!hold) de_req = 1'b0;
  endtask

  task automatic run(input logic [17:0] a, input logic [3:0] nb,
                     input logic rnw, input logic [31:0] wd,
                     input bit hold, input bit drop);
    int lat;
    logic [3:0] eb;
    xfer(a, nb, rnw, wd, hold, drop, lat);
    eb = exp_be(rnw, nb);
    chk("latency", 32'(lat), 32'(exp_lat(rnw, nb)));
    chk("cs_cycles", 32'(cs_n), 32'(exp_lat(rnw, nb) - 1));
    chk("we_cycles", 32'(we_n), (!rnw && nb != 4'hF) ? 32'(W) : 32'h0);
    chk("be_or", 32'(be_or), 32'(eb));
    chk("be_and", 32'(be_and), 32'(eb));
    if (rnw) exp_rd = ref_get(a);
    else ref_write(a, nb, wd);
    chk("r_data", rd_at_ack, exp_rd);
    chk("mem_word", sram[a], ref_get(a));
  endtask

  initial begin
    int  a0, a1;
    bit  acked;
    bit  hold;
    rst = 1'b1; de_req = 1'b0; de_addr = '0; de_nbyte = '0;
    de_rnw = 1'b0; de_w_data = '0;
    #1;
    chk("rst_ack", 32'(de_ack), 32'h0);
    chk("rst_rdata", de_r_data, 32'h0);
    chk("rst_cs", 32'(mem_cs), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_be", 32'(mem_be), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // full write, byte write, read-back, hold across write, null write
    run(18'h00010, 4'b0000, 1'b0, 32'hDEADBEEF, 0, 0);
    chk("full_write_word", sram[18'h00010], 32'hDEADBEEF);
    run(18'h00020, 4'b0000, 1'b0, 32'h11223344, 0, 0);
    run(18'h00020, 4'b1101, 1'b0, 32'hAABBCCDD, 0, 0);
    chk("byte_write_word", sram[18'h00020], 32'h1122CC44);
    run(18'h00010, 4'b0000, 1'b1, 32'h0, 0, 0);
    chk("readback", rd_at_ack, 32'hDEADBEEF);
    run(18'h00030, 4'b0000, 1'b0, 32'h01020304, 0, 0);
    chk("rdata_hold", de_r_data, 32'hDEADBEEF);
    run(18'h00020, 4'b1111, 1'b0, 32'hFFFFFFFF, 0, 0);
    chk("null_write_word", sram[18'h00020], 32'h1122CC44);
    run(18'h00031, 4'b0000, 1'b0, 32'h77777777, 0, 1);

    // back-to-back with de_req held
    run(18'h00040, 4'b0000, 1'b0, 32'hA0000000, 1, 0);
    a0 = last_ack;
    for (int i = 1; i < 4; i++) begin
      run(18'(18'h00040 + i), 4'b0000, 1'b0, 32'hA0000000 + i, i != 3, 0);
      chk("b2b_spacing", 32'(last_ack - a0), 32'(W + 2));
      a0 = last_ack;
    end
    for (int i = 0; i < 4; i++)
      chk("b2b_word", sram[18'h00040 + i], 32'hA0000000 + i);

    // reset in the first ACCESS cycle
    de_req = 1'b1; de_addr = 18'h00050; de_nbyte = 4'b0000;
    de_rnw = 1'b0; de_w_data = 32'h55AA55AA;
    @(posedge clk); #1;
    chk("pre_rst_cs", 32'(mem_cs), 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_cs", 32'(mem_cs), 32'h0);
    chk("mid_rst_we", 32'(mem_we), 32'h0);
    chk("mid_rst_ack", 32'(de_ack), 32'h0);
    chk("mid_rst_rdata", de_r_data, 32'h0);
    exp_rd = 32'h0;
    de_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    acked = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (de_ack || mem_cs) acked = 1'b1;
    end
    chk("no_ack_after_rst", 32'(acked), 32'h0);
    run(18'h00050, 4'b0000, 1'b0, 32'hCAFEF00D, 0, 0);
    run(18'h00050, 4'b0000, 1'b1, 32'h0, 0, 0);
    chk("post_rst_read", rd_at_ack, 32'hCAFEF00D);

    // random traffic against the reference memory
    for (int t = 0; t < 60; t++) begin
      a1 = 32'h100 + $urandom_range(0, 15);
      hold = 1'($urandom_range(0, 1));
      run(18'(a1), 4'($urandom), $urandom_range(0, 2) == 0, $urandom, hold,
          !hold && ($urandom_range(0, 3) == 0));
      if (!hold) repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
    de_req = 1'b0;
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
